// File: rtl/lock_pkg.sv
// Shared types and widths for the lockout supervisor and its helpers.
package lock_pkg;

  localparam int unsigned KEY_W  = 10;
  localparam int unsigned FAIL_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWaitResult,
    StOpen,
    StLockout
  } lock_state_e;

  // Saturating increment for the consecutive-failure counter.
  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lockout_supervisor_edge.sv
// Rising-edge detector: one-cycle pulse when the input goes from low to high.
module edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);

  logic d_q;

  // Previous sample; cleared on reset so a level already high afterwards reads as an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign pulse_o = d_i & ~d_q;

endmodule

// File: rtl/lockout_supervisor.sv
// Sequences entry attempts against combo_lock, counts consecutive failures and
// imposes escalating lockouts, with a sticky alarm on repeated max-length lockouts.
module lockout_supervisor
  import lock_pkg::*;
#(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned BASE_LOCKOUT   = 1000,
  parameter int unsigned MAX_SHIFT      = 4,
  parameter int unsigned RESULT_TIMEOUT = 16,
  parameter int unsigned TIMER_W        = 24
) (
  input  logic               clk,
  input  logic               hard_rst,
  input  logic [KEY_W-1:0]   keypad_in,
  input  logic               enter_in,
  input  logic               rst_in,
  input  logic               clr_in,
  input  logic               unlock,
  input  logic               incorrect,
  output logic [KEY_W-1:0]   keypad_out,
  output logic               enter_out,
  output logic               rst_out,
  output logic               clr_out,
  output logic               locked_out,
  output logic [FAIL_W-1:0]  fail_count,
  output logic [TIMER_W-1:0] lockout_remaining,
  output logic               alarm
);

  localparam int unsigned LVL_W  = $clog2(MAX_SHIFT + 2);
  localparam int unsigned WAIT_W = $clog2(RESULT_TIMEOUT + 1);
  localparam logic [63:0] TimerMax = (64'd1 << TIMER_W) - 64'd1;

  logic enter_rise, unlock_rise, incorrect_rise;

  edge_detect u_enter_edge (
    .clk_i   (clk),
    .rst_i   (hard_rst),
    .d_i     (enter_in),
    .pulse_o (enter_rise)
  );

  edge_detect u_unlock_edge (
    .clk_i   (clk),
    .rst_i   (hard_rst),
    .d_i     (unlock),
    .pulse_o (unlock_rise)
  );

  edge_detect u_incorrect_edge (
    .clk_i   (clk),
    .rst_i   (hard_rst),
    .d_i     (incorrect),
    .pulse_o (incorrect_rise)
  );

  lock_state_e        state_q, state_d;
  logic [FAIL_W-1:0]  fail_q, fail_d, fail_inc;
  logic [LVL_W-1:0]   level_q, level_d, shift;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [TIMER_W-1:0] timer_q, timer_d, lock_len;
  logic [63:0]        dur_wide;
  logic               alarm_q, alarm_d;
  logic [KEY_W-1:0]   keypad_q, keypad_d;
  logic               enter_q, enter_d;
  logic               rst_q, rst_d;
  logic               clr_q, clr_d;
  logic               locked_q, locked_d;

  // Lockout length for the current level, clamped to the timer width rather than wrapping.
  always_comb begin
    shift    = (level_q > LVL_W'(MAX_SHIFT)) ? LVL_W'(MAX_SHIFT) : level_q;
    dur_wide = 64'(BASE_LOCKOUT) << shift;
    lock_len = (dur_wide > TimerMax) ? '1 : dur_wide[TIMER_W-1:0];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    level_d  = level_q;
    wait_d   = wait_q;
    timer_d  = timer_q;
    alarm_d  = alarm_q;
    keypad_d = '0;
    enter_d  = 1'b0;
    clr_d    = 1'b0;
    rst_d    = rst_in;
    locked_d = 1'b0;
    fail_inc = sat_inc(fail_q);

    unique case (state_q)
      StIdle: begin
        keypad_d = keypad_in;
        clr_d    = clr_in;
        if (enter_rise) begin
          enter_d = 1'b1;
          wait_d  = '0;
          state_d = StWaitResult;
        end
      end
      StWaitResult: begin
        if (unlock_rise) begin
          state_d = StOpen;
        end else if (incorrect_rise) begin
          if (fail_inc == FAIL_W'(MAX_FAILS)) begin
            state_d  = StLockout;
            timer_d  = lock_len;
            locked_d = 1'b1;
            fail_d   = '0;
            // Alarm only once a max-length lockout has already been served.
            if (level_q > LVL_W'(MAX_SHIFT)) begin
              alarm_d = 1'b1;
            end
            if (level_q < LVL_W'(MAX_SHIFT + 1)) begin
              level_d = level_q + 1'b1;
            end
          end else begin
            fail_d  = fail_inc;
            state_d = StIdle;
          end
        end else if (wait_q == WAIT_W'(RESULT_TIMEOUT - 1)) begin
          state_d = StIdle;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StOpen: begin
        keypad_d = keypad_in;
        clr_d    = clr_in;
        enter_d  = enter_rise;
        // unlock was high on entry, so a low level here means it fell.
        if (!unlock || rst_in) begin
          state_d = StIdle;
        end
      end
      StLockout: begin
        if (timer_q <= TIMER_W'(1)) begin
          timer_d = '0;
          state_d = StIdle;
        end else begin
          timer_d  = timer_q - 1'b1;
          locked_d = 1'b1;
        end
      end
    endcase

    // A successful unlock anywhere forgives past failures and escalation.
    if (unlock_rise) begin
      fail_d  = '0;
      level_d = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (hard_rst) begin
      state_q  <= StIdle;
      fail_q   <= '0;
      level_q  <= '0;
      wait_q   <= '0;
      timer_q  <= '0;
      alarm_q  <= 1'b0;
      keypad_q <= '0;
      enter_q  <= 1'b0;
      rst_q    <= 1'b0;
      clr_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fail_q   <= fail_d;
      level_q  <= level_d;
      wait_q   <= wait_d;
      timer_q  <= timer_d;
      alarm_q  <= alarm_d;
      keypad_q <= keypad_d;
      enter_q  <= enter_d;
      rst_q    <= rst_d;
      clr_q    <= clr_d;
      locked_q <= locked_d;
    end
  end

  assign keypad_out        = keypad_q;
  assign enter_out         = enter_q;
  assign rst_out           = rst_q;
  assign clr_out           = clr_q;
  assign locked_out        = locked_q;
  assign fail_count        = fail_q;
  assign lockout_remaining = timer_q;
  assign alarm             = alarm_q;

endmodule
